fp_mult_arbiter: RTL and testbench

//  Shares one combinational fp_mult instance among NUM_REQ requesters (e.g. Y/Cb/Cr

---
 rtl/fp_mult_arbiter.sv | 138 +++++++++++++
 tb/tb_fp_mult_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_arbiter.sv
`default_nettype none
// fp_mult_arbiter: one signed fixed-point multiplier shared by NUM_REQ valid/ready requesters.
// Define FP_MULT_ARB_RR_EN for round-robin arbitration; otherwise lowest asserted index wins.
module fp_mult_arbiter #(
  parameter int FP_WIDTH = 16,
  parameter int FP_FRAC  = 8,
  parameter int NUM_REQ  = 3,
  parameter int ID_W     = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*FP_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*FP_WIDTH-1:0] req_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [FP_WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]             rsp_id
);

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W < $clog2(NUM_REQ)) begin : g_bad_cfg
      $error("fp_mult_arbiter: NUM_REQ must be 2..8 and ID_W >= clog2(NUM_REQ)");
    end
  endgenerate

  logic                         rsp_valid_q, rsp_valid_d;
  logic [FP_WIDTH-1:0]          rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]              rsp_id_q, rsp_id_d;
  logic                         can_accept;
  logic                         accept;
  logic                         win_found;
  logic [ID_W-1:0]              win_idx;
  logic [FP_WIDTH-1:0]          op_a, op_b;
  logic signed [2*FP_WIDTH-1:0] prod_full;
  logic [FP_WIDTH-1:0]          product;

`ifdef FP_MULT_ARB_RR_EN
  logic [ID_W-1:0] ptr_q, ptr_d;
`endif

  assign can_accept = !rsp_valid_q || rsp_ready;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    op_a      = '0;
    op_b      = '0;
`ifdef FP_MULT_ARB_RR_EN
    begin : rr_search
      int best_dist;
      int dist;
      best_dist = NUM_REQ;
      dist      = 0;
      // Winner is the valid requester closest to the pointer going upward with wrap.
      for (int i = 0; i < NUM_REQ; i++) begin
        dist = i - int'(ptr_q);
        if (dist < 0) dist = dist + NUM_REQ;
        if (req_valid[i] && dist < best_dist) begin
          best_dist = dist;
          win_found = 1'b1;
          win_idx   = ID_W'(i);
          op_a      = req_a[i*FP_WIDTH +: FP_WIDTH];
          op_b      = req_b[i*FP_WIDTH +: FP_WIDTH];
        end
      end
    end
`else
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(i);
        op_a      = req_a[i*FP_WIDTH +: FP_WIDTH];
        op_b      = req_b[i*FP_WIDTH +: FP_WIDTH];
      end
    end
`endif
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = rst_n && can_accept && win_found && (win_idx == ID_W'(i));
    end
  end

  assign accept = |req_ready;

  // Product keeps FP_FRAC fraction bits; upper bits are dropped, so overflow wraps.
  assign prod_full = $signed(op_a) * $signed(op_b);
  assign product   = prod_full[FP_FRAC +: FP_WIDTH];

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = product;
      rsp_id_d    = win_idx;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

`ifdef FP_MULT_ARB_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_mult_arbiter.sv
`default_nettype none
// tb_fp_mult_arbiter: vector table, directed corner sequences and random traffic vs. a reference model.
module tb_fp_mult_arbiter;
  localparam int N  = 3;
  localparam int W  = 16;
  localparam int F  = 8;
  localparam int IW = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [IW-1:0]  rsp_id;

  fp_mult_arbiter #(.FP_WIDTH(W), .FP_FRAC(F), .NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model state: what the result register should hold, plus the rotation pointer.
  logic         m_valid;
  logic [W-1:0] m_data;
  logic [IW-1:0] m_id;
  int           m_ptr;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = (sa * sb) >>> F;
    return W'(p);
  endfunction

  function automatic int ref_arb(input logic [N-1:0] v, input int p);
`ifdef FP_MULT_ARB_RR_EN
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
`else
    for (int k = 0; k < N; k++) if (v[k]) return k;
`endif
    return -1;
  endfunction

  function automatic logic [N*W-1:0] pack1(input int idx, input logic [W-1:0] x);
    logic [N*W-1:0] r;
    r = '0;
    r = r | ((N*W)'(x) << (idx * W));
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_id    = '0;
    m_ptr   = 0;
  endtask

  // One clock cycle: drive on the falling edge, check everything just after, then advance the model.
  task automatic drive_cycle(input logic [N-1:0] v, input logic [N*W-1:0] a,
                             input logic [N*W-1:0] b, input logic rr);
    int w;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
    #1;
    w = ref_arb(v, m_ptr);
    exp_rdy = '0;
    if ((!m_valid || rr) && w >= 0) exp_rdy = N'(1) << w;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_data",  32'(rsp_data),  32'(m_data));
    chk("rsp_id",    32'(rsp_id),    32'(m_id));
    if (exp_rdy != '0) begin
      m_valid = 1'b1;
      m_data  = ref_mult(W'(a >> (w * W)), W'(b >> (w * W)));
      m_id    = IW'(w);
      m_ptr   = (w + 1) % N;
    end else if (rr) begin
      m_valid = 1'b0;
    end
  endtask

  // Asynchronous reset pulse placed between clock edges, with all requesters asking.
  task automatic async_reset();
    @(negedge clk);
    req_valid = '1;
    rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_rsp_data",  32'(rsp_data),  32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_req_ready_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
    model_reset();
  endtask

  initial begin
    logic [N*W-1:0] ra, rb;
    tbl[0] = '{16'h0180, 16'h0180, 16'h0240};
    tbl[1] = '{16'h0200, 16'hFF00, 16'hFE00};
    tbl[2] = '{16'h0080, 16'h0080, 16'h0040};
    tbl[3] = '{16'h0100, 16'h1234, 16'h1234};
    tbl[4] = '{16'hFF00, 16'hFF00, 16'h0100};
    tbl[5] = '{16'h4000, 16'h0400, 16'h0000};
    tbl[6] = '{16'h0001, 16'h0001, 16'h0000};
    tbl[7] = '{16'hFFFF, 16'h0001, 16'hFFFF};
    tbl[8] = '{16'h7FFF, 16'h7FFF, 16'hFF00};

    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    req_valid = '1;
    #1;
    chk("init_req_ready", 32'(req_ready), 32'd0);
    chk("init_rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    req_valid = '0;

    // Single requester 0, one product per row, drained on the following cycle.
    for (int i = 0; i < 9; i++) begin
      drive_cycle(3'b001, pack1(0, tbl[i].a), pack1(0, tbl[i].b), 1'b1);
      chk("tbl_grant", 32'(req_ready), 32'b001);
      drive_cycle(3'b000, '0, '0, 1'b1);
      chk("tbl_valid", 32'(rsp_valid), 32'd1);
      chk("tbl_data",  32'(rsp_data),  32'(tbl[i].exp));
      chk("tbl_id",    32'(rsp_id),    32'd0);
    end
    drive_cycle(3'b000, '0, '0, 1'b1);

    // Back-to-back from requester 2 then requester 1.
    drive_cycle(3'b100, pack1(2, 16'h0200), pack1(2, 16'hFF00), 1'b1);
    drive_cycle(3'b010, pack1(1, 16'h0080), pack1(1, 16'h0080), 1'b1);
    chk("b2b_first_data", 32'(rsp_data), 32'hFE00);
    chk("b2b_first_id",   32'(rsp_id),   32'd2);
    drive_cycle(3'b000, '0, '0, 1'b1);
    chk("b2b_second_data", 32'(rsp_data), 32'h0040);
    chk("b2b_second_id",   32'(rsp_id),   32'd1);
    drive_cycle(3'b000, '0, '0, 1'b1);

    // Backpressure: result held while consumer stalls, then regrant on release.
    drive_cycle(3'b001, pack1(0, 16'h0180), pack1(0, 16'h0180), 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(3'b111, {3{16'h0100}}, {3{16'h0300}}, 1'b0);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_data",  32'(rsp_data),  32'h0240);
      chk("bp_id",    32'(rsp_id),    32'd0);
    end
    drive_cycle(3'b111, {3{16'h0100}}, {3{16'h0300}}, 1'b1);
    chk("bp_regrant", 32'(|req_ready), 32'd1);
    @(negedge clk);
    #1;
    chk("bp_still_valid", 32'(rsp_valid), 32'd1);
    chk("bp_new_data", 32'(rsp_data), 32'h0300);

    // Reset while a result is pending.
    async_reset();

    // All requesters hammering with the consumer always ready.
    for (int i = 0; i < 7; i++) begin
      drive_cycle(3'b111, {16'h0300, 16'h0200, 16'h0100}, {3{16'h0100}}, 1'b1);
      if (i > 0) begin
`ifdef FP_MULT_ARB_RR_EN
        chk("seq_id", 32'(rsp_id), 32'((i - 1) % 3));
`else
        chk("seq_id", 32'(rsp_id), 32'd0);
`endif
      end
    end
    drive_cycle(3'b000, '0, '0, 1'b1);

    // Requester 1 withdraws while the result is stalled; pointer must not move.
    async_reset();
    drive_cycle(3'b001, pack1(0, 16'h0100), pack1(0, 16'h0100), 1'b1);
    drive_cycle(3'b010, pack1(1, 16'h0100), pack1(1, 16'h0100), 1'b0);
    drive_cycle(3'b010, pack1(1, 16'h0100), pack1(1, 16'h0100), 1'b0);
    drive_cycle(3'b000, '0, '0, 1'b0);
    drive_cycle(3'b101, {16'h0200, 16'h0000, 16'h0100}, {3{16'h0100}}, 1'b1);
`ifdef FP_MULT_ARB_RR_EN
    chk("drop_grant", 32'(req_ready), 32'b100);
`else
    chk("drop_grant", 32'(req_ready), 32'b001);
`endif
    drive_cycle(3'b000, '0, '0, 1'b1);
`ifdef FP_MULT_ARB_RR_EN
    chk("drop_id", 32'(rsp_id), 32'd2);
`else
    chk("drop_id", 32'(rsp_id), 32'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      ra = (N*W)'({$urandom(), $urandom()});
      rb = (N*W)'({$urandom(), $urandom()});
      drive_cycle(N'($urandom_range(0, 7)), ra, rb, ($urandom_range(0, 3) != 0));
    end
    drive_cycle(3'b000, '0, '0, 1'b1);
    drive_cycle(3'b000, '0, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
